// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store engine of the RISC-V pipeline. It takes the EX/MEM
// control fields, the ALU result as the byte address and the store data. It runs
// one req/ack transaction per access on the data-memory bus and holds the
// pipeline with stall until that transaction finishes. Load data is lane-shifted
// and sign- or zero-extended before it goes to MEM/WB.
//
// Parameters:
//   TIMEOUT        REQ cycles, counted on an 8-bit counter, before bus_error fires.
// Optional feature:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses skip the
//                         bus and pulse misalign_fault. When undefined, the output
//                         is tied 0 and the access runs word-aligned.
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   MEM_control[6:0]      [6] MemWrite, [2:0] funct3 load/store type
//   WB_control[3:0]       [2] MemtoReg (load)
//   ALUResult, StoreData  byte address, store source value
//   stall                 holds PC/IF/ID/EX/EX-MEM while an access is in flight
//   load_data             extended load result, held until the next load ends
//   mem_done, bus_error, misalign_fault   one-cycle status pulses in DONE
//   dmem_*                data-memory req/ack bus
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  MEM_control,
  input  logic [3:0]  WB_control,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        mem_done,
  output logic        bus_error,
  output logic        misalign_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_t      state;
  logic [2:0]  lat_type;
  logic [1:0]  lat_off;
  logic [7:0]  tmo_cnt;

  logic access;
  logic is_store;

  // Jump/branch fields and the remaining WB fields belong to other stages.
  logic unused_ctrl;
  assign unused_ctrl = ^{MEM_control[5:3], WB_control[3], WB_control[1:0]};

  assign is_store = MEM_control[6];
  assign access   = MEM_control[6] | WB_control[2];
  // Combinational in IDLE so the access is held on its very first cycle.
  assign stall    = ((state == IDLE) && access) || (state == REQ);

  function automatic logic [3:0] store_be(input logic [2:0] t, input logic [1:0] off);
    case (t)
      3'b000:  store_be = 4'b0001 << off;
      3'b001:  store_be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] t, input logic [31:0] sd);
    case (t)
      3'b000:  store_wdata = {4{sd[7:0]}};
      3'b001:  store_wdata = {2{sd[15:0]}};
      3'b010:  store_wdata = sd;
      default: store_wdata = 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] t, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] shifted;
    shifted = rd >> {off, 3'b000};
    case (t)
      3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_extract = {24'b0, shifted[7:0]};
      3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_extract = {16'b0, shifted[15:0]};
      3'b010:  load_extract = shifted;
      default: load_extract = 32'b0;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    misaligned = ((t[1:0] == 2'b01) && off[0]) || ((t[1:0] == 2'b10) && (off != 2'b00));
  endfunction
`else
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      lat_type   <= 3'b0;
      lat_off    <= 2'b0;
      tmo_cnt    <= 8'b0;
      load_data  <= 32'b0;
      mem_done   <= 1'b0;
      bus_error  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'b0;
      dmem_be    <= 4'b0;
      dmem_wdata <= 32'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
`endif
    end else begin
      mem_done  <= 1'b0;
      bus_error <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
`endif
      case (state)
        // IDLE: latch the transaction so the bus stays stable while EX/MEM is held
        IDLE: begin
          if (access) begin
            lat_type   <= MEM_control[2:0];
            lat_off    <= ALUResult[1:0];
            tmo_cnt    <= 8'b0;
            dmem_we    <= is_store;
            dmem_addr  <= {ALUResult[31:2], 2'b00};
            dmem_be    <= is_store ? store_be(MEM_control[2:0], ALUResult[1:0]) : 4'b1111;
            dmem_wdata <= is_store ? store_wdata(MEM_control[2:0], StoreData) : 32'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            if (misaligned(MEM_control[2:0], ALUResult[1:0])) begin
              state          <= DONE;
              mem_done       <= 1'b1;
              misalign_fault <= 1'b1;
            end else
`endif
            begin
              state    <= REQ;
              dmem_req <= 1'b1;
            end
          end
        end
        // REQ: wait for ack; an ack on the final count still wins over the timeout
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            mem_done <= 1'b1;
            if (!dmem_we) load_data <= load_extract(lat_type, lat_off, dmem_rdata);
          end else if (tmo_cnt == TMO_MAX) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            mem_done  <= 1'b1;
            bus_error <= 1'b1;
            if (!dmem_we) load_data <= 32'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        // DONE: stall is low here, so the pipeline advances exactly once
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. Transactions are driven as pipeline accesses,
// and a bus responder acks after a chosen number of REQ cycles. Hand-derived
// expectations are queued when each access is issued. They are popped and
// compared when the DUT signals completion.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [6:0]  MEM_control;
  logic [3:0]  WB_control;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic        stall;
  logic [31:0] load_data;
  logic        mem_done;
  logic        bus_error;
  logic        misalign_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_control(MEM_control), .WB_control(WB_control),
    .ALUResult(ALUResult), .StoreData(StoreData),
    .stall(stall), .load_data(load_data), .mem_done(mem_done),
    .bus_error(bus_error), .misalign_fault(misalign_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ld;
    logic        berr;
    logic        mis;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_ld = 32'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ld, input logic berr, input logic mis,
                              input int stalls, input int reqs, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd, input logic we);
    exp_t e;
    e.ld = ld; e.berr = berr; e.mis = mis; e.stalls = stalls; e.reqs = reqs;
    e.addr = addr; e.be = be; e.wd = wd; e.we = we;
    return e;
  endfunction

  // ack_at: REQ cycle (1-based) in which the responder asserts ack; 0 = never.
  task automatic run(input string tag, input logic we, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                     input int ack_at, input exp_t e);
    int   stalls;
    int   reqs;
    bit   done;
    exp_t got;
    @(negedge CLK);
    MEM_control = {we, 3'b000, t};
    WB_control  = we ? 4'b0000 : 4'b1101;
    ALUResult   = a;
    StoreData   = sd;
    sb.push_back(e);
    #1;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge CLK);
      if (stall) stalls++;
      if (mem_done) begin
        done     = 1'b1;
        dmem_ack = 1'b0;
        chk({tag, ".stall_done"}, {31'b0, stall}, 32'd0);
      end else if (dmem_req) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, ".addr"}, dmem_addr, sb[0].addr);
          chk({tag, ".we"}, {31'b0, dmem_we}, {31'b0, sb[0].we});
          chk({tag, ".be"}, {28'b0, dmem_be}, {28'b0, sb[0].be});
          if (sb[0].we) chk({tag, ".wdata"}, dmem_wdata, sb[0].wd);
        end
        dmem_ack   = (reqs == ack_at);
        dmem_rdata = rd;
      end else begin
        dmem_ack = 1'b0;
      end
    end
    MEM_control = 7'b0;
    WB_control  = 4'b0;
    dmem_ack    = 1'b0;
    if (!done) begin
      chk({tag, ".done_seen"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      chk({tag, ".load_data"}, load_data, got.ld);
      chk({tag, ".bus_error"}, {31'b0, bus_error}, {31'b0, got.berr});
      chk({tag, ".misalign"}, {31'b0, misalign_fault}, {31'b0, got.mis});
      chk({tag, ".stalls"}, stalls, got.stalls);
      chk({tag, ".reqs"}, reqs, got.reqs);
      last_ld = got.ld;
    end
    @(negedge CLK);
    chk({tag, ".pulse_end"}, {30'b0, mem_done, bus_error}, 32'd0);
  endtask

  initial begin
    RESET = 1'b0; MEM_control = 7'b0; WB_control = 4'b0;
    ALUResult = 32'b0; StoreData = 32'b0; dmem_ack = 1'b0; dmem_rdata = 32'b0;
    repeat (2) @(negedge CLK);
    chk("rst.req", {31'b0, dmem_req}, 32'd0);
    chk("rst.stall", {31'b0, stall}, 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.flags", {29'b0, mem_done, bus_error, misalign_fault}, 32'd0);
    chk("rst.bus", {dmem_addr[27:0], dmem_be}, 32'd0);
    RESET = 1'b1;

    // Non-access instruction (Jump/Branch bits only): no stall, no bus activity
    @(negedge CLK);
    MEM_control = 7'b0111000;
    #1;
    chk("nop.stall", {31'b0, stall}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("nop.req", {30'b0, dmem_req, mem_done}, 32'd0);
    MEM_control = 7'b0;

    run("sw104", 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 2,
        mk(last_ld, 0, 0, 3, 2, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b1));
    run("sb103", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1,
        mk(last_ld, 0, 0, 2, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1));
    run("sh10a", 1'b1, 3'b001, 32'h10A, 32'h1234ABCD, 32'h0, 1,
        mk(last_ld, 0, 0, 2, 1, 32'h108, 4'b1100, 32'hABCDABCD, 1'b1));
    run("lb202", 1'b0, 3'b000, 32'h202, 32'h0, 32'h12F03456, 1,
        mk(32'hFFFFFFF0, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
    run("lhu202", 1'b0, 3'b101, 32'h202, 32'h0, 32'h12F03456, 1,
        mk(32'h000012F0, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
    run("lh200", 1'b0, 3'b001, 32'h200, 32'h0, 32'h00008001, 3,
        mk(32'hFFFF8001, 0, 0, 4, 3, 32'h200, 4'b1111, 32'h0, 1'b0));
    run("lbu201", 1'b0, 3'b100, 32'h201, 32'h0, 32'h00008000, 1,
        mk(32'h00000080, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
    // Ack on the cycle the counter reaches TIMEOUT is still a success
    run("lw_edge", 1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 5,
        mk(32'hCAFEF00D, 0, 0, 6, 5, 32'h204, 4'b1111, 32'h0, 1'b0));
    // A store leaves the last load result untouched
    run("sw_hold", 1'b1, 3'b010, 32'h110, 32'h5555AAAA, 32'h0, 1,
        mk(last_ld, 0, 0, 2, 1, 32'h110, 4'b1111, 32'h5555AAAA, 1'b1));
    run("lw_tmo", 1'b0, 3'b010, 32'h208, 32'h0, 32'h0, 0,
        mk(32'h0, 1, 0, 6, 5, 32'h208, 4'b1111, 32'h0, 1'b0));
    run("lbu_pre", 1'b0, 3'b100, 32'h200, 32'h0, 32'h0000007E, 1,
        mk(32'h0000007E, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
    run("ld_undef", 1'b0, 3'b011, 32'h200, 32'h0, 32'hFFFFFFFF, 1,
        mk(32'h0, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
    run("lbu_pre2", 1'b0, 3'b100, 32'h200, 32'h0, 32'h00000033, 1,
        mk(32'h00000033, 0, 0, 2, 1, 32'h200, 4'b1111, 32'h0, 1'b0));
`ifdef MEM_MISALIGN_TRAP_EN
    run("lw301", 1'b0, 3'b010, 32'h301, 32'h0, 32'h11223344, 1,
        mk(last_ld, 0, 1, 1, 0, 32'h300, 4'b1111, 32'h0, 1'b0));
`else
    run("lw301", 1'b0, 3'b010, 32'h301, 32'h0, 32'h11223344, 1,
        mk(32'h00112233, 0, 0, 2, 1, 32'h300, 4'b1111, 32'h0, 1'b0));
`endif

    // Reset during REQ: req and stall drop at once, and a late ack is ignored
    @(negedge CLK);
    MEM_control = 7'b0000010; WB_control = 4'b1101; ALUResult = 32'h400;
    repeat (3) @(negedge CLK);
    chk("mid.req_before", {31'b0, dmem_req}, 32'd1);
    RESET = 1'b0; MEM_control = 7'b0; WB_control = 4'b0;
    #1;
    chk("mid.req", {31'b0, dmem_req}, 32'd0);
    chk("mid.stall", {31'b0, stall}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
    repeat (3) @(negedge CLK);
    chk("mid.late_ack", {30'b0, mem_done, dmem_req}, 32'd0);
    chk("mid.load_data", load_data, 32'd0);
    dmem_ack = 1'b0;
    last_ld = 32'b0;

    run("sw_after", 1'b1, 3'b010, 32'h500, 32'h0BADF00D, 32'h0, 1,
        mk(last_ld, 0, 0, 2, 1, 32'h500, 4'b1111, 32'h0BADF00D, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
